adc_serial_sampler: RTL

//  Upstream front end of the moving-average filter. Runs a 3-wire serial ADC
//  (CS_n/SCLK/SDO) at a fixed sample rate and deserialises each 8-bit MSB-first

---
 rtl/adc_serial_sampler.sv | 89 ++++++++
 1 files changed

// File: rtl/adc_serial_sampler.sv
// adc_serial_sampler: drives a 3-wire serial ADC (CS_n/SCLK/SDO) at a fixed sample rate,
// deserialises each MSB-first word and hands it to the moving-average filter.
//   Clk          in   system clock, rising edge
//   Rst_n        in   asynchronous active-low reset
//   Start_en     in   1 = free-run sampling, 0 = stop after the current word
//   Adc_sdo      in   serial data from the ADC
//   Adc_cs_n     out  ADC chip select, active low
//   Adc_sclk     out  ADC serial clock, idles low
//   X1           out  last complete sample
//   Sample_vld   out  one-cycle pulse when X1 updates
//   Avg_enable_n out  one-cycle low pulse aligned with Sample_vld
//   Busy         out  high from CS_n fall through DONE
//   Sample_cnt   out  wrapping count of captured samples
module adc_serial_sampler #(
   parameter int DATA_W        = 8,
   parameter int SCLK_DIV      = 4,
   parameter int SAMPLE_PERIOD = 64
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start_en,
   input  logic              Adc_sdo,
   output logic              Adc_cs_n,
   output logic              Adc_sclk,
   output logic [DATA_W-1:0] X1,
   output logic              Sample_vld,
   output logic              Avg_enable_n,
   output logic              Busy,
   output logic [15:0]       Sample_cnt
);
   // a word takes 2*DATA_W half-periods plus DONE, and CS_n must then stay high at least one more cycle
   localparam int PERIOD = SAMPLE_PERIOD > 2*DATA_W*SCLK_DIV+2 ? SAMPLE_PERIOD : 2*DATA_W*SCLK_DIV+2;
   localparam int PW     = $clog2(PERIOD);
   localparam int DW     = SCLK_DIV > 1 ? $clog2(SCLK_DIV) : 1;
   localparam int HW     = $clog2(2*DATA_W);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT} state_t;

   state_t            state, state_nx;
   logic [PW-1:0]     per;
   logic [DW-1:0]     div;
   logic [HW-1:0]     half;
   logic [DATA_W-1:0] sr;
   logic              half_end, last, per_end;

   assign half_end = div == DW'(SCLK_DIV-1);
   assign last     = half_end && half == HW'(2*DATA_W-1);
   assign per_end  = per == PW'(PERIOD-1);

   always_comb begin
      state_nx     = state;
      Adc_cs_n     = state != SHIFT;
      Adc_sclk     = state == SHIFT && half[0];
      Sample_vld   = state == DONE;
      Avg_enable_n = state != DONE;
      Busy         = state == SHIFT || state == DONE;
      case (state)
         IDLE:    state_nx = Start_en ? SHIFT : IDLE;
         SHIFT:   state_nx = last ? DONE : SHIFT;
         DONE:    state_nx = WAIT;
         default: state_nx = per_end ? (Start_en ? SHIFT : IDLE) : WAIT;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= IDLE;
         per        <= '0;
         div        <= '0;
         half       <= '0;
         sr         <= '0;
         X1         <= '0;
         Sample_cnt <= '0;
      end else begin
         state <= state_nx;
         // the period counter reads 0 in the cycle CS_n goes low
         per   <= (state_nx == SHIFT && state != SHIFT) ? '0 : per + PW'(1);
         div   <= (state != SHIFT || half_end) ? '0 : div + DW'(1);
         half  <= state != SHIFT ? '0 : half + HW'(half_end);
         // capture on the edge that ends an even (low) half-period, i.e. the edge raising SCLK
         if (state == SHIFT && half_end && !half[0])
            sr <= {sr[DATA_W-2:0], Adc_sdo};
         if (state == SHIFT && last) begin
            X1         <= sr;
            Sample_cnt <= Sample_cnt + 16'd1;
         end
      end
   end
endmodule
